div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle divide controller for the EXE stage of the five-stage MIPS pipeline. It launches a 32-iteration radix-2 restoring divide when DIV/DIVU sits in EXE and raises a stall request for the duration. The existing hazard logic folds that request into PC_Wr/ID_Wr/EXE write enables, alongside the load-use stall. On completion it holds the quotient and remainder valid for the HI/LO write, and it aborts cleanly on an exception flush.

## Interface
Parameters:
- DIV_CYCLES, 32, iteration count; equals the operand width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- EXE_IsDiv  in  1  EXE holds DIV or DIVU
- EXE_Signed  in  1  1 = DIV, 0 = DIVU; sampled at issue
- EXE_rs_data  in  32  dividend, forwarded value; sampled at issue
- EXE_rt_data  in  32  divisor, forwarded value; sampled at issue
- Flush  in  1  exception/ERET flush of EXE; aborts any operation
- Pipe_Hold  in  1  downstream stall; the EXE instruction will not advance this cycle
- Div_Busy  out  1  stall request (combinational); 1 = hold PC, ID and EXE
- Div_Valid  out  1  results valid for the HI/LO write
- Div_Quotient  out  32  to LO
- Div_Remainder  out  32  to HI

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE → BUSY when EXE_IsDiv=1 and Flush=0 (issue cycle).
  - At issue: latch the sign flag, the operand magnitudes and the result-sign bits, and clear the counter.
- BUSY: one restoring iteration per cycle.
  - 5-bit counter increments each cycle.
  - BUSY → DONE on the cycle the counter equals DIV_CYCLES-1.
- DONE:
  - Apply sign correction:
    - Quotient is negated when the operand signs differ (signed only).
    - Remainder takes the dividend's sign.
  - Div_Valid=1; Quotient and Remainder are stable.
  - DONE → IDLE when Pipe_Hold=0.
  - DONE with Pipe_Hold=1: stay in DONE, outputs held.
  - The EXE_IsDiv still present while in DONE does not re-issue.
- Div_Busy = (IDLE & EXE_IsDiv & ~Flush) | BUSY. It is 0 in DONE.
- Flush has priority in every state:
  - The next state is IDLE.
  - Div_Busy=0 in the same cycle.
  - Div_Valid is never raised for the aborted instruction.
- Divisor zero:
  - No trap; the full 32 cycles still run.
  - Raw result is Q=32'hFFFF_FFFF, R=|dividend|; sign correction then applies as normal.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF gives Q=0x8000_0000, R=0.
- Arithmetic: a 33-bit partial remainder with a trial subtraction each cycle. All magnitudes are 32-bit unsigned; negation is two's complement at 32 bits.
- Back-to-back divides: the second DIV enters EXE after the first leaves DONE and issues from IDLE with no bubble beyond its own latency.

## Timing
- Reset values:
  - state=IDLE, counter=0.
  - Div_Valid=0, Div_Busy=0 (given EXE_IsDiv=0).
  - Div_Quotient=0, Div_Remainder=0.
- Issue at cycle T: Div_Busy=1 in T through T+32, i.e. 33 stall cycles.
- DONE is entered at T+33: Div_Valid=1 and Div_Busy=0, so the instruction advances at the end of T+33 if Pipe_Hold=0.
- Div_Valid stays 1 for every cycle spent in DONE and falls the cycle after DONE exits.
- Flush in any BUSY cycle: Div_Busy falls combinationally that cycle, and state=IDLE the next cycle.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values.
- Operands are sampled only at issue. Forwarding changes during BUSY are ignored.

## Structure
- Shared package CPU_Defines.svh:
  - `div_state_t` enum {DIV_IDLE, DIV_BUSY, DIV_DONE}.
  - `DIV_CYCLES` constant.
- Sub-module `div_iter`: purely combinational single restoring step.
  - Inputs: partial remainder, dividend-shift bit, divisor.
  - Outputs: next remainder, quotient bit.
- The sequencer owns the FSM, counter, operand/result registers and sign fix-up.

## Test plan
- DIVU 100 / 7 → Div_Busy high exactly 33 cycles; DONE gives Q=14, R=2; Div_Valid 1 for one cycle with Pipe_Hold=0.
- DIV -7 / 2 → Q=0xFFFF_FFFD, R=0xFFFF_FFFF; DIV 0x8000_0000 / 0xFFFF_FFFF → Q=0x8000_0000, R=0.
- DIVU 0x1234 / 0 → 33 busy cycles, Q=0xFFFF_FFFF, R=0x1234, no other side effect.
- DIVU issued, Flush pulsed at T+10 → Div_Busy=0 at T+10, state IDLE at T+11, Div_Valid never asserted; a following DIV issues normally.
- Pipe_Hold=1 for 3 cycles on DONE entry → Div_Valid and results held 4 cycles, no re-issue; exit when Pipe_Hold drops.
- rst asserted at T+20 → all outputs return to their reset values asynchronously; after release, DIVU 9 / 3 gives Q=3, R=0.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the EXE-stage divide sequencer.
// Holds the FSM encoding, iteration count and a small sign helper.
package div_sequencer_pkg;

   localparam int DIV_CYCLES = 32;
   localparam int DIV_W      = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   // Two's complement negate at 32 bits when neg is set.
   function automatic logic [DIV_W-1:0] neg_if(
      input logic             neg,
      input logic [DIV_W-1:0] v
   );
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_sequencer_iter.sv
// One radix-2 restoring divide step, purely combinational.
// Shifts the next dividend bit into the partial remainder and trial-subtracts.
module div_iter
   import div_sequencer_pkg::*;
(
   input  logic [DIV_W:0]   rem_i,
   input  logic             bit_i,
   input  logic [DIV_W-1:0] dvs_i,
   output logic [DIV_W:0]   rem_o,
   output logic             q_o
);

   logic [DIV_W:0] shifted;
   logic [DIV_W:0] diff;

   // Trial subtraction; keep the difference only when it does not go negative.
   always_comb begin
      shifted = {rem_i[DIV_W-1:0], bit_i};
      diff    = shifted - {1'b0, dvs_i};
      q_o     = (shifted >= {1'b0, dvs_i});
      rem_o   = q_o ? diff : shifted;
   end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU controller for the EXE stage.
// Stalls the front of the pipe while iterating, then presents HI/LO results.
module div_sequencer #(
   parameter int DIV_CYCLES = div_sequencer_pkg::DIV_CYCLES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        EXE_IsDiv,
   input  logic        EXE_Signed,
   input  logic [31:0] EXE_rs_data,
   input  logic [31:0] EXE_rt_data,
   input  logic        Flush,
   input  logic        Pipe_Hold,
   output logic        Div_Busy,
   output logic        Div_Valid,
   output logic [31:0] Div_Quotient,
   output logic [31:0] Div_Remainder
);

   import div_sequencer_pkg::*;

   localparam int             CNT_W    = $clog2(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

   div_state_t state_q, state_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             signed_q, signed_d;
   logic             nega_q, nega_d;
   logic             negb_q, negb_d;
   logic [DIV_W-1:0] dvd_q, dvd_d;
   logic [DIV_W-1:0] dvs_q, dvs_d;
   logic [DIV_W:0]   prem_q, prem_d;
   logic [DIV_W-1:0] quo_q, quo_d;
   logic [DIV_W-1:0] rmd_q, rmd_d;

   logic             issue;
   logic             step;
   logic             last;
   logic             negq;
   logic [DIV_W:0]   it_rem;
   logic             it_q;
   logic [DIV_W-1:0] q_raw;

   assign issue = (state_q == DIV_IDLE) & EXE_IsDiv & ~Flush;
   assign step  = (state_q == DIV_BUSY) & ~Flush;
   assign last  = step & (cnt_q == CNT_LAST);
   assign negq  = signed_q & (nega_q ^ negb_q);
   assign q_raw = {dvd_q[DIV_W-2:0], it_q};

   div_iter u_iter (
      .rem_i (prem_q),
      .bit_i (dvd_q[DIV_W-1]),
      .dvs_i (dvs_q),
      .rem_o (it_rem),
      .q_o   (it_q)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= DIV_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a flush always returns to IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DIV_IDLE: if (EXE_IsDiv) state_d = DIV_BUSY;
         DIV_BUSY: if (cnt_q == CNT_LAST) state_d = DIV_DONE;
         DIV_DONE: if (!Pipe_Hold) state_d = DIV_IDLE;
         default:  state_d = DIV_IDLE;
      endcase
      if (Flush) state_d = DIV_IDLE;
   end

   // Outputs: stall request covers the issue cycle and every BUSY cycle.
   always_comb begin
      Div_Busy      = issue | step;
      Div_Valid     = (state_q == DIV_DONE) & ~Flush;
      Div_Quotient  = quo_q;
      Div_Remainder = rmd_q;
   end

   // Datapath next state: capture magnitudes at issue, iterate, fix signs last.
   always_comb begin
      cnt_d    = cnt_q;
      signed_d = signed_q;
      nega_d   = nega_q;
      negb_d   = negb_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      prem_d   = prem_q;
      quo_d    = quo_q;
      rmd_d    = rmd_q;
      if (issue) begin
         signed_d = EXE_Signed;
         nega_d   = EXE_Signed & EXE_rs_data[DIV_W-1];
         negb_d   = EXE_Signed & EXE_rt_data[DIV_W-1];
         dvd_d    = neg_if(nega_d, EXE_rs_data);
         dvs_d    = neg_if(negb_d, EXE_rt_data);
         prem_d   = '0;
         cnt_d    = '0;
      end else if (step) begin
         cnt_d  = cnt_q + 1'b1;
         prem_d = it_rem;
         dvd_d  = q_raw;
         if (last) begin
            quo_d = neg_if(negq, q_raw);
            rmd_d = neg_if(nega_q, it_rem[DIV_W-1:0]);
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         signed_q <= 1'b0;
         nega_q   <= 1'b0;
         negb_q   <= 1'b0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         prem_q   <= '0;
         quo_q    <= '0;
         rmd_q    <= '0;
      end else begin
         cnt_q    <= cnt_d;
         signed_q <= signed_d;
         nega_q   <= nega_d;
         negb_q   <= negb_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         prem_q   <= prem_d;
         quo_q    <= quo_d;
         rmd_q    <= rmd_d;
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer.
// Hand-computed quotient/remainder vectors plus flush, hold and reset cases.
module tb_div_sequencer;

   logic        clk;
   logic        rst;
   logic        EXE_IsDiv;
   logic        EXE_Signed;
   logic [31:0] EXE_rs_data;
   logic [31:0] EXE_rt_data;
   logic        Flush;
   logic        Pipe_Hold;
   logic        Div_Busy;
   logic        Div_Valid;
   logic [31:0] Div_Quotient;
   logic [31:0] Div_Remainder;

   int n_vec;
   int n_bad;

   div_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .EXE_IsDiv     (EXE_IsDiv),
      .EXE_Signed    (EXE_Signed),
      .EXE_rs_data   (EXE_rs_data),
      .EXE_rt_data   (EXE_rt_data),
      .Flush         (Flush),
      .Pipe_Hold     (Pipe_Hold),
      .Div_Busy      (Div_Busy),
      .Div_Valid     (Div_Valid),
      .Div_Quotient  (Div_Quotient),
      .Div_Remainder (Div_Remainder)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Issue one divide, count stall cycles, then check results through
   // `hold` extra DONE cycles held by Pipe_Hold.
   task automatic run_div(input string tag, input logic sg,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er,
                          input int hold);
      int busy_n;
      bit seen;
      busy_n      = 0;
      seen        = 0;
      EXE_IsDiv   = 1'b1;
      EXE_Signed  = sg;
      EXE_rs_data = a;
      EXE_rt_data = b;
      Pipe_Hold   = (hold > 0);
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         if (Div_Valid) begin
            seen = 1;
         end else begin
            if (Div_Busy) busy_n++;
            @(posedge clk);
            #1;
            EXE_rs_data = a ^ 32'h5a5a_0f0f;
            EXE_rt_data = b + 32'd3;
         end
      end
      chk({tag, ".done"}, 32'(seen), 32'd1);
      chk({tag, ".busy"}, 32'(busy_n), 32'd33);
      if (seen) begin
         for (int k = 0; k <= hold; k++) begin
            if (k > 0) @(negedge clk);
            chk({tag, ".valid"}, 32'(Div_Valid), 32'd1);
            chk({tag, ".nobusy"}, 32'(Div_Busy), 32'd0);
            chk({tag, ".q"}, Div_Quotient, eq);
            chk({tag, ".r"}, Div_Remainder, er);
            @(posedge clk);
            #1;
            Pipe_Hold = (k + 1 < hold);
         end
      end
      Pipe_Hold = 1'b0;
      EXE_IsDiv = 1'b0;
      @(negedge clk);
      chk({tag, ".vfall"}, 32'(Div_Valid), 32'd0);
      chk({tag, ".idle"}, 32'(Div_Busy), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int vcnt;
      n_vec       = 0;
      n_bad       = 0;
      rst         = 1'b1;
      EXE_IsDiv   = 1'b0;
      EXE_Signed  = 1'b0;
      EXE_rs_data = '0;
      EXE_rt_data = '0;
      Flush       = 1'b0;
      Pipe_Hold   = 1'b0;
      #12;
      chk("rst.busy", 32'(Div_Busy), 32'd0);
      chk("rst.valid", 32'(Div_Valid), 32'd0);
      chk("rst.q", Div_Quotient, 32'd0);
      chk("rst.r", Div_Remainder, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_div("divu100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
      run_div("div_m7_2", 1'b1, 32'hffff_fff9, 32'd2,
              32'hffff_fffd, 32'hffff_ffff, 0);
      run_div("div_7_m2", 1'b1, 32'd7, 32'hffff_fffe,
              32'hffff_fffd, 32'd1, 0);
      run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hffff_ffff,
              32'h8000_0000, 32'd0, 0);
      run_div("divu_big", 1'b0, 32'h8000_0000, 32'hffff_ffff,
              32'd0, 32'h8000_0000, 0);
      run_div("divu_z", 1'b0, 32'h0000_1234, 32'd0,
              32'hffff_ffff, 32'h0000_1234, 0);
      run_div("divu_by1", 1'b0, 32'hffff_ffff, 32'd1,
              32'hffff_ffff, 32'd0, 0);

      // Flush at T+10 aborts the operation.
      EXE_IsDiv   = 1'b1;
      EXE_Signed  = 1'b0;
      EXE_rs_data = 32'd1000;
      EXE_rt_data = 32'd10;
      @(negedge clk);
      chk("fl.issue", 32'(Div_Busy), 32'd1);
      for (int i = 1; i < 10; i++) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("fl.t9busy", 32'(Div_Busy), 32'd1);
      @(posedge clk);
      #1;
      Flush = 1'b1;
      @(negedge clk);
      chk("fl.busy0", 32'(Div_Busy), 32'd0);
      chk("fl.valid0", 32'(Div_Valid), 32'd0);
      @(posedge clk);
      #1;
      Flush     = 1'b0;
      EXE_IsDiv = 1'b0;
      vcnt      = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (Div_Valid || Div_Busy) vcnt++;
         @(posedge clk);
         #1;
      end
      chk("fl.quiet", 32'(vcnt), 32'd0);
      run_div("fl.next", 1'b1, 32'hffff_ff9c, 32'd7,
              32'hffff_fff2, 32'hffff_fffe, 0);

      run_div("hold3", 1'b0, 32'd50, 32'd8, 32'd6, 32'd2, 3);

      // Asynchronous reset in the middle of an operation.
      EXE_IsDiv   = 1'b1;
      EXE_Signed  = 1'b0;
      EXE_rs_data = 32'd77;
      EXE_rt_data = 32'd5;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("mid.busy", 32'(Div_Busy), 32'd1);
      #2;
      EXE_IsDiv = 1'b0;
      rst       = 1'b1;
      #1;
      chk("mrst.busy", 32'(Div_Busy), 32'd0);
      chk("mrst.valid", 32'(Div_Valid), 32'd0);
      chk("mrst.q", Div_Quotient, 32'd0);
      chk("mrst.r", Div_Remainder, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_div("divu9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
